rv_dmem_ws: RTL and testbench
=============================

# rv_dmem_ws

Parametrised data-memory block for the RV32 core's memory stage, replacing the single-cycle word-only data memory. It adds RV32I sub-word loads/stores (byte/halfword lanes, sign/zero extension), a configurable number of wait states with a stall output to the pipeline, misalignment detection, and a sticky error flag. It sits between the core's M-stage signals (address, write data, write enable) and the core's load-result input. It drives the core's stall alongside the fetch stall.

## Interface
- `DEPTH_WORDS`, default 1024: memory size in 32-bit words; power of two, minimum 4.
- `WAIT_STATES`, default 2: extra access cycles, range 0..7.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high reset.
- `req`  in  1: M-stage memory access valid (load or store).
- `we`  in  1: 1 = store, 0 = load; qualified by `req`.
- `funct3`  in  3: 000 b, 001 h, 010 w, 100 bu, 101 hu. Stores use 000/001/010 only.
- `addr`  in  32: byte address.
- `wdata`  in  32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rdata`  out  32: extended load result, registered.
- `stall`  out  1: hold the pipeline.
- `done`  out  1: one-cycle pulse when the access completes.
- `misalign`  out  1: combinational; the current request is misaligned.
- `err`  out  1: sticky; set on any misaligned request.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE, `req`=1, aligned:
  - Latch `addr`, `we`, `funct3` and `wdata`.
  - Load the counter with WAIT_STATES and go to BUSY.
  - `stall`=1 this cycle.
- IDLE, `req`=1, misaligned:
  - `misalign`=1, `err` set at the edge.
  - No memory access, no state change, `stall`=0, `rdata` unchanged.
  - Misaligned means: h/hu/sh with `addr[0]`≠0, or w with `addr[1:0]`≠0.
- BUSY:
  - `stall`=1.
  - While counter≠0: decrement.
  - When counter=0:
    - Load: register the extended read into `rdata`.
    - Store: write the enabled byte lanes.
    - Then go to DONE.
- DONE: `stall`=0, `done`=1, then go to IDLE unconditionally. The next `req` is sampled in IDLE.
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`. Upper bits are ignored, so addresses wrap modulo DEPTH_WORDS×4.
- Lane selection:
  - b/bu/sb: lane = `addr[1:0]`.
  - h/hu/sh: lanes `addr[1]`×2 and `addr[1]`×2+1.
  - w: all four lanes.
- Load extension: b/h sign-extend bit 7/15 of the selected data; bu/hu zero-extend. Stores write only the selected lanes; other bytes are preserved.
- Illegal `funct3` (011, 110, 111) is treated as w.
- Stores never modify `rdata`.
- Reset:
  - FSM → IDLE, counter=0.
  - Outputs: `rdata`=0, `stall`=0, `done`=0, `err`=0. `misalign` follows its inputs.
  - Memory contents are not cleared.
- Reset during BUSY/DONE aborts the access; a pending store is discarded.
- `req` deasserting during BUSY does not cancel the access; the latched request completes.

## Timing
- Aligned request first seen in IDLE at cycle 0:
  - `stall`=1 in cycles 0..WAIT_STATES+1.
  - `done`=1 and `rdata` valid in cycle WAIT_STATES+2.
  - Total latency is WAIT_STATES+3 cycles.
- WAIT_STATES=0: 3 cycles (IDLE, BUSY, DONE).
- Store data is written at the rising edge ending the final BUSY cycle. A load issued in the following IDLE returns the new value (read-after-write coherent).
- `rdata` holds its value until the next completed load.
- `misalign` is combinational from `req`, `funct3` and `addr` in IDLE, and is 0 in BUSY/DONE.
- Back-to-back requests: minimum spacing is WAIT_STATES+3 cycles. IDLE is always visited for one cycle.

## Test plan
- **Word RAW, WAIT_STATES=2:**
  - Stimulus: sw 0xDEADBEEF to 0x40, then lw 0x40.
  - Required: `stall` high 4 cycles per access; `done` in cycle 4; `rdata`=0xDEADBEEF.
- **Byte lanes:**
  - Stimulus: sw 0x11223344 to 0x80; sb 0xAA to 0x82; lw 0x80.
  - Required: `rdata`=0x11AA3344.
- **Extension:**
  - Stimulus: mem[0x10]=0x8000_80F0; lb 0x10; lbu 0x10; lh 0x12; lhu 0x12.
  - Required: `rdata` = 0xFFFFFFF0, 0x000000F0, 0xFFFF8000, 0x00008000 respectively.
- **Misaligned:**
  - Stimulus: lw 0x41, then sh 0x43.
  - Required: `misalign`=1 in the same cycle, `stall`=0, memory and `rdata` unchanged, `err`=1 until reset.
- **Reset mid-store:**
  - Stimulus: sw 0x12345678 to 0x20 (prior value 0); assert `reset` in the second BUSY cycle; then lw 0x20.
  - Required: `stall`/`done`/`rdata`/`err` = 0 after reset; load returns 0.
- **Wrap, DEPTH_WORDS=16, WAIT_STATES=0:**
  - Stimulus: sw 0xCAFEF00D to 0x44; lw 0x04.
  - Required: `rdata`=0xCAFEF00D; each access stalls exactly 2 cycles.

Source files
------------

// File: rtl/rv_dmem_ws.sv
// rv_dmem_ws: RV32 M-stage data memory with byte/halfword lanes, sign/zero
// extension, a programmable number of wait states, misalignment detection
// and a sticky error flag.
//
// Handshake: an access is accepted when req=1 is seen in IDLE with an aligned
// address. The block then asserts stall until the access completes, and
// pulses done for one cycle in the DONE state, where rdata is valid for loads.
// The request is latched on acceptance, so req and the other inputs may change
// freely while BUSY/DONE. A misaligned request in IDLE is rejected in the same
// cycle: misalign=1, stall=0, err is set, and nothing else changes.
module rv_dmem_ws #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        misalign,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Access size codes: 0 = byte, 1 = halfword, 2 = word.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        fire;

  logic [AW+1:0] addr_q;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [31:0]   wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] widx;
  logic [31:0]   rword;
  logic [31:0]   rshift;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   rext;
  logic [3:0]    be;
  logic [31:0]   wlanes;
  logic          req_mis;
  logic          accept;

  // Address bits above the memory size are ignored, so accesses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AW+2];

  // Byte/halfword/word size of a funct3 code; illegal codes behave as word.
  function automatic logic [1:0] size_code(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return SZ_B;
      3'b001, 3'b101: return SZ_H;
      default:        return SZ_W;
    endcase
  endfunction

  // True when the address is not naturally aligned for the access size.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a_lo);
    case (size_code(f3))
      SZ_H:    return a_lo[0];
      SZ_W:    return a_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  assign req_mis  = req && is_misaligned(funct3, addr[1:0]);
  assign misalign = (state_q == S_IDLE) && req_mis;
  assign accept   = (state_q == S_IDLE) && req && !req_mis;

  // Next-state, counter and handshake outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    done    = 1'b0;
    fire    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          stall   = 1'b1;
          cnt_d   = 3'(WAIT_STATES);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          fire    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read path and store lane steering, all from the latched request.
  always_comb begin
    widx   = addr_q[AW+1:2];
    rword  = mem[widx];
    rshift = rword >> {addr_q[1:0], 3'b000};
    rbyte  = rshift[7:0];
    rhalf  = addr_q[1] ? rword[31:16] : rword[15:0];
    case (f3_q)
      3'b000:  rext = {{24{rbyte[7]}}, rbyte};
      3'b100:  rext = {24'd0, rbyte};
      3'b001:  rext = {{16{rhalf[15]}}, rhalf};
      3'b101:  rext = {16'd0, rhalf};
      default: rext = rword;
    endcase
    case (size_code(f3_q))
      SZ_B: begin
        be     = 4'b0001 << addr_q[1:0];
        wlanes = {4{wdata_q[7:0]}};
      end
      SZ_H: begin
        be     = addr_q[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{wdata_q[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        wlanes = wdata_q;
      end
    endcase
  end

  // FSM state, wait counter, sticky error and registered load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      err     <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (misalign) begin
        err <= 1'b1;
      end
      if (fire && !we_q) begin
        rdata <= rext;
      end
    end
  end

  // Request latch, captured only when an aligned access is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      addr_q  <= addr[AW+1:0];
      we_q    <= we;
      f3_q    <= funct3;
      wdata_q <= wdata;
    end
  end

  // Storage array: not cleared by reset; a store in flight is dropped by reset.
  always_ff @(posedge clk) begin
    if (!reset && fire && we_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[widx][8*i +: 8] <= wlanes[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_rv_dmem_ws.sv
// tb_rv_dmem_ws: directed table, hand-written corner sequences and random
// traffic for rv_dmem_ws, checked against a byte-addressed reference memory.
module tb_rv_dmem_ws;

  localparam int WS0 = 2;
  localparam int WS1 = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req, we, sel;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;

  logic [31:0] rdata0, rdata1, rdata;
  logic        stall0, stall1, stall;
  logic        done0, done1, done;
  logic        mis0, mis1, misalign;
  logic        err0, err1, err;
  logic        req0, req1;

  // sel steers the request to the default instance (0) or the small one (1).
  assign req0     = req && !sel;
  assign req1     = req && sel;
  assign rdata    = sel ? rdata1 : rdata0;
  assign stall    = sel ? stall1 : stall0;
  assign done     = sel ? done1  : done0;
  assign misalign = sel ? mis1   : mis0;
  assign err      = sel ? err1   : err0;

  rv_dmem_ws #(.DEPTH_WORDS(1024), .WAIT_STATES(WS0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata0), .stall(stall0),
    .done(done0), .misalign(mis0), .err(err0)
  );

  rv_dmem_ws #(.DEPTH_WORDS(16), .WAIT_STATES(WS1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req1), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata1), .stall(stall1),
    .done(done1), .misalign(mis1), .err(err1)
  );

  // ---------------- scoreboard / reference ----------------
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  bmem [4096];
  logic [31:0] last_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic model_mis(input logic [2:0] f3, input logic [31:0] a);
    int n = nbytes(f3);
    return (a % n) != 0;
  endfunction

  function automatic logic [31:0] model_ld(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v = 32'd0;
    logic [11:0] idx;
    int n = nbytes(f3);
    for (int i = 0; i < n; i++) begin
      idx = 12'(a + 32'(i));
      v = v | (32'(bmem[idx]) << (8 * i));
    end
    if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [11:0] idx;
    logic [31:0] sh;
    int n = nbytes(f3);
    for (int i = 0; i < n; i++) begin
      idx = 12'(a + 32'(i));
      sh  = wd >> (8 * i);
      bmem[idx] = sh[7:0];
    end
  endtask

  // ---------------- driver tasks ----------------
  // One accepted access; returns stall cycles, done cycle index, rdata at done,
  // and how often misalign was seen after cycle 0. Inputs are scrambled while
  // the access is in flight.
  task automatic access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int stalls, output int done_cyc,
                        output logic [31:0] rd, output int busy_mis);
    stalls = 0; done_cyc = -1; rd = '0; busy_mis = 0;
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (c > 0 && misalign) busy_mis++;
      if (done) begin done_cyc = c; rd = rdata; end
      @(posedge clk); #1;
      if (done_cyc >= 0) begin
        req = 1'b0;
        break;
      end
      req    = 1'($urandom_range(0, 1));
      we     = 1'($urandom_range(0, 1));
      funct3 = 3'($urandom_range(0, 7));
      addr   = $urandom;
      wdata  = $urandom;
    end
    req = 1'b0;
  endtask

  // Access on instance 0, checked against the reference memory.
  task automatic op(input string nm, input logic w, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    logic [31:0] exp_rd;
    int st, dc, bm;
    if (w) begin
      model_st(f3, a, wd);
      exp_rd = last_rd;
    end else begin
      exp_rd  = model_ld(f3, a);
      last_rd = exp_rd;
    end
    access(w, f3, a, wd, st, dc, rd, bm);
    chk({nm, " stall_cycles"}, 32'(st), 32'(WS0 + 2));
    chk({nm, " done_cycle"}, 32'(dc), 32'(WS0 + 2));
    chk({nm, " rdata"}, rd, exp_rd);
    chk({nm, " misalign_busy"}, 32'(bm), 32'd0);
  endtask

  // Misaligned request in IDLE: rejected at once, err set, nothing else moves.
  task automatic mis_op(input string nm, input logic w, input logic [2:0] f3, input logic [31:0] a);
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = $urandom;
    @(negedge clk);
    chk({nm, " misalign"}, 32'(misalign), 32'd1);
    chk({nm, " stall"}, 32'(stall), 32'd0);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk({nm, " err"}, 32'(err), 32'd1);
    chk({nm, " rdata_kept"}, rdata, last_rd);
    chk({nm, " no_start"}, {30'd0, stall, done}, 32'd0);
    @(posedge clk); #1;
  endtask

  // Store to 0x20 aborted by reset raised during BUSY cycle rc.
  task automatic reset_mid_store(input int rc);
    logic [31:0] rd;
    op("clr20", 1'b1, 3'b010, 32'h20, 32'h0, rd);
    req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h20; wdata = 32'h1234_5678;
    for (int c = 0; c < rc; c++) begin
      @(posedge clk); #1;
      req = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid outputs", {29'd0, stall, done, err}, 32'd0);
    chk("rst_mid rdata", rdata, 32'd0);
    last_rd = 32'd0;
    @(posedge clk); #1;
    op("rst_mid lw20", 1'b0, 3'b010, 32'h20, 32'h0, rd);
    chk("rst_mid lw20 value", rd, 32'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [31:0] rd;
    int st, dc, bm;

    tbl[0]  = '{1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, 32'h0};
    tbl[1]  = '{1'b0, 3'b010, 32'h40, 32'h0,         32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 3'b010, 32'h80, 32'h1122_3344, 32'h0};
    tbl[3]  = '{1'b1, 3'b000, 32'h82, 32'hFFFF_FFAA, 32'h0};
    tbl[4]  = '{1'b0, 3'b010, 32'h80, 32'h0,         32'h11AA_3344};
    tbl[5]  = '{1'b1, 3'b010, 32'h10, 32'h8000_80F0, 32'h0};
    tbl[6]  = '{1'b0, 3'b000, 32'h10, 32'h0,         32'hFFFF_FFF0};
    tbl[7]  = '{1'b0, 3'b100, 32'h10, 32'h0,         32'h0000_00F0};
    tbl[8]  = '{1'b0, 3'b001, 32'h12, 32'h0,         32'hFFFF_8000};
    tbl[9]  = '{1'b0, 3'b101, 32'h12, 32'h0,         32'h0000_8000};
    tbl[10] = '{1'b1, 3'b001, 32'h42, 32'h1234_5678, 32'h0};
    tbl[11] = '{1'b0, 3'b010, 32'h40, 32'h0,         32'h5678_BEEF};
    tbl[12] = '{1'b0, 3'b001, 32'h40, 32'h0,         32'hFFFF_BEEF};
    tbl[13] = '{1'b0, 3'b000, 32'h43, 32'h0,         32'h0000_0056};
    tbl[14] = '{1'b0, 3'b011, 32'h40, 32'h0,         32'h5678_BEEF};

    // Reset state.
    reset = 1'b1; req = 1'b0; we = 1'b0; sel = 1'b0;
    funct3 = 3'd0; addr = '0; wdata = '0; last_rd = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset outputs", {29'd0, stall, done, err}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Bring the first 64 words to a known value.
    for (int i = 0; i < 64; i++) begin
      model_st(3'b010, 32'(i * 4), 32'd0);
      access(1'b1, 3'b010, 32'(i * 4), 32'd0, st, dc, rd, bm);
    end

    // Table-driven directed vectors.
    for (int i = 0; i < 15; i++) begin
      op($sformatf("tbl%0d", i), tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].wd, rd);
      if (!tbl[i].w) chk($sformatf("tbl%0d value", i), rd, tbl[i].exp);
    end

    // Misaligned requests leave memory and rdata alone.
    mis_op("mis lw41", 1'b0, 3'b010, 32'h41);
    mis_op("mis sh43", 1'b1, 3'b001, 32'h43);
    op("mis check", 1'b0, 3'b010, 32'h40, 32'h0, rd);
    chk("mis mem_kept", rd, 32'h5678_BEEF);
    chk("mis err_sticky", 32'(err), 32'd1);

    // Random traffic against the reference memory.
    for (int i = 0; i < 200; i++) begin
      logic        w;
      logic [2:0]  f3;
      logic [31:0] a, hi;
      logic [2:0]  ld_codes [8];
      ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
      w  = ($urandom_range(0, 2) == 0);
      f3 = w ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 7)];
      hi = $urandom;
      a  = {hi[31:12], 4'd0, 8'($urandom_range(0, 255))};
      if ($urandom_range(0, 1) == 1) begin
        a = a & ~32'(nbytes(f3) - 1);
      end
      if (model_mis(f3, a)) mis_op("rand mis", w, f3, a);
      else                  op("rand", w, f3, a, $urandom, rd);
    end

    // Reset aborting a store: second BUSY cycle, then final BUSY cycle.
    reset_mid_store(2);
    reset_mid_store(3);
    chk("post-reset err clear", 32'(err), 32'd0);

    // Address wrap on the 16-word, zero-wait instance.
    sel = 1'b1;
    access(1'b1, 3'b010, 32'h44, 32'hCAFE_F00D, st, dc, rd, bm);
    chk("wrap sw stall_cycles", 32'(st), 32'(WS1 + 2));
    chk("wrap sw done_cycle", 32'(dc), 32'(WS1 + 2));
    chk("wrap sw rdata", rd, 32'd0);
    access(1'b0, 3'b010, 32'h04, 32'h0, st, dc, rd, bm);
    chk("wrap lw stall_cycles", 32'(st), 32'(WS1 + 2));
    chk("wrap lw done_cycle", 32'(dc), 32'(WS1 + 2));
    chk("wrap lw rdata", rd, 32'hCAFE_F00D);
    sel = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
